// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC control path.
// Optional performance counters are enabled with CORDIC_CTRL_PERF_EN.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } cordic_ctrl_state_t;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  localparam int unsigned PERF_W = 32;

endpackage : cordic_pkg

// File: rtl/cordic_ctrl_perf.sv
// Performance counters: completed output handshakes and stalled DONE cycles.
// Instantiated by cordic_ctrl only when CORDIC_CTRL_PERF_EN is defined.
module cordic_ctrl_perf
  import cordic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs,
  input  logic              stall,
  output logic [PERF_W-1:0] perf_ops,
  output logic [PERF_W-1:0] perf_stall
);

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (hs)    perf_ops   <= perf_ops + PERF_W'(1);
      if (stall) perf_stall <= perf_stall + PERF_W'(1);
    end
  end

endmodule : cordic_ctrl_perf

// File: rtl/cordic_ctrl.sv
// Control sequencer for the non-pipelined CORDIC datapath: accepts one
// operation, steps BIT_WIDTH-1 micro-rotations steered by dp_dir, then holds
// the result until consumed. Abort, step-count watchdog and sticky err.
// Define CORDIC_CTRL_PERF_EN to add the perf_ops / perf_stall counter ports.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH       = 32,
  parameter int unsigned LOG_2_BIT_WIDTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_mode,
  input  logic abort,
  output logic out_valid,
  input  logic out_ready,
  output logic out_mode,
  output logic busy,
  output logic err,
  output logic dp_load_regs,
  output logic dp_add,
  output logic dp_sub,
  output logic dp_iter,
  output logic dp_mode,
  input  logic dp_reached_target,
  input  logic dp_dir
`ifdef CORDIC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ops,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  localparam int unsigned CNT_W = LOG_2_BIT_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIT_WIDTH - 1);

  cordic_ctrl_state_t state, state_nx;
  logic               mode_q;
  logic [CNT_W-1:0]   step_cnt;

  logic acc;
  logic at_last;
  logic rot_step;
  logic rot_end;
  logic rot_bad;

  // Handshake and step decode shared by the next-state and output logic.
  always_comb begin
    in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    acc      = in_valid && in_ready;
    at_last  = (step_cnt == LAST_STEP);
    rot_step = (state == ROTATE) && !abort && !dp_reached_target && !at_last;
    rot_end  = (state == ROTATE) && !abort && (dp_reached_target || at_last);
    // Only target reached exactly at the last step is a clean finish.
    rot_bad  = rot_end && !(dp_reached_target && at_last);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort outranks target/watchdog completion.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc) state_nx = ROTATE;
      ROTATE: begin
        if (abort)        state_nx = IDLE;
        else if (rot_end) state_nx = DONE;
      end
      DONE:    if (out_ready) state_nx = acc ? ROTATE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: micro-ops only on rotating steps, result flags in DONE.
  always_comb begin
    dp_load_regs = 1'b0;
    dp_iter      = 1'b0;
    dp_add       = 1'b0;
    dp_sub       = 1'b0;
    dp_mode      = mode_q;
    out_valid    = 1'b0;
    out_mode     = mode_q;
    busy         = 1'b0;
    dp_load_regs = acc;
    if (acc) dp_mode = in_mode;
    if (rot_step) begin
      dp_iter = 1'b1;
      dp_add  = dp_dir;
      dp_sub  = !dp_dir;
    end
    out_valid = (state == DONE);
    busy      = (state == ROTATE) || (state == DONE);
  end

  // Operation context: latched mode, step counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_ROTATE;
      step_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (acc) begin
        mode_q   <= in_mode;
        step_cnt <= '0;
      end else if (rot_step) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
      if (rot_bad) err <= 1'b1;
    end
  end

`ifdef CORDIC_CTRL_PERF_EN
  logic perf_hs;
  logic perf_stall_ev;

  // Handshake and stall events feeding the counters.
  always_comb begin
    perf_hs       = out_valid && out_ready;
    perf_stall_ev = out_valid && !out_ready;
  end

  cordic_ctrl_perf u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .hs         (perf_hs),
    .stall      (perf_stall_ev),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
  );
`endif

endmodule : cordic_ctrl

// File: tb/tb_cordic_ctrl.sv
// Self-checking bench for cordic_ctrl with a small datapath stub
// (step index + random direction) and a transaction-level reference model.
module tb_cordic_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_mode, abort;
  logic out_valid, out_ready, out_mode, busy, err;
  logic dp_load_regs, dp_add, dp_sub, dp_iter, dp_mode;
  logic dp_reached_target, dp_dir;
`ifdef CORDIC_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  cordic_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_mode           (in_mode),
    .abort             (abort),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_mode          (out_mode),
    .busy              (busy),
    .err               (err),
    .dp_load_regs      (dp_load_regs),
    .dp_add            (dp_add),
    .dp_sub            (dp_sub),
    .dp_iter           (dp_iter),
    .dp_mode           (dp_mode),
    .dp_reached_target (dp_reached_target),
    .dp_dir            (dp_dir)
`ifdef CORDIC_CTRL_PERF_EN
    ,
    .perf_ops          (perf_ops),
    .perf_stall        (perf_stall)
`endif
  );

  // Datapath stub: step index reaches its target after tgt_q iterations
  // (31 normal, smaller = premature, >31 = never).
  int         tgt_sel;
  int         tgt_q;
  logic [5:0] idx;
  logic       dir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      tgt_q <= 31;
      dir   <= 1'b0;
    end else begin
      dir <= 1'($urandom);
      if (dp_load_regs) begin
        idx   <= '0;
        tgt_q <= tgt_sel;
      end else if (dp_iter) begin
        idx <= idx + 6'd1;
      end
    end
  end

  assign dp_reached_target = (int'(idx) == tgt_q);
  assign dp_dir            = dir;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 result held.
  // During running, m_k counts cycles since accept; micro-ops occur for
  // m_k = 1..min(tgt,31), completion at m_k = ops+1, err unless tgt == 31.
  int m_phase = 0, m_k = 0, m_ops = 0, m_tgt = 31;
  bit m_mode = 1'b0, m_err = 1'b0;

  always @(negedge clk) begin
    bit e_ready, e_acc, e_op;
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_mode = 1'b0; m_err = 1'b0;
      chk("reset_outputs_low",
          int'({dp_load_regs, dp_add, dp_sub, dp_iter, out_valid, busy, err}), 0);
    end else begin
      e_ready = (m_phase == 0) || (m_phase == 2 && out_ready);
      e_acc   = in_valid && e_ready;
      e_op    = (m_phase == 1) && !abort && (m_k <= m_ops);
      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("dp_load_regs", int'(dp_load_regs), int'(e_acc));
      chk("dp_iter", int'(dp_iter), int'(e_op));
      chk("dp_add", int'(dp_add), int'(e_op && dp_dir));
      chk("dp_sub", int'(dp_sub), int'(e_op && !dp_dir));
      chk("dp_mode", int'(dp_mode), int'(e_acc ? in_mode : m_mode));
      chk("out_valid", int'(out_valid), int'(m_phase == 2));
      if (m_phase == 2) chk("out_mode", int'(out_mode), int'(m_mode));
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("err", int'(err), int'(m_err));
      if (m_phase == 1) begin
        if (abort) m_phase = 0;
        else if (m_k == m_ops + 1) begin
          m_phase = 2;
          if (m_tgt != 31) m_err = 1'b1;
        end else m_k++;
      end else if (m_phase == 2 && out_ready) begin
        m_phase = 0;
      end
      if (e_acc) begin
        m_phase = 1; m_k = 1; m_mode = in_mode; m_tgt = tgt_sel;
        m_ops = (tgt_sel < 31) ? tgt_sel : 31;
      end
    end
  end

  // Wait for a result starting at the first cycle after accept (k = 1).
  task automatic wait_result(input int abort_k, input int stall, input bit chain,
                             input bit c_mode, input int c_tgt,
                             output int lat, output int nops);
    bit fin;
    fin = 1'b0; lat = -1; nops = 0;
    for (int k = 1; k <= 120 && !fin; k++) begin
      if (k == abort_k) abort = 1'b1;
      #1;
      if (dp_add || dp_sub) nops++;
      if (out_valid) begin
        lat = k; fin = 1'b1;
      end else if (k == abort_k) begin
        @(posedge clk); #1; abort = 1'b0; #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_idle", int'(busy), 0);
        repeat (3) begin
          @(posedge clk); #2;
          chk("abort_no_valid", int'(out_valid), 0);
        end
        fin = 1'b1;
      end else begin
        @(posedge clk); #1; abort = 1'b0;
      end
    end
    if (!fin) chk("result_timeout", 0, 1);
    if (lat > 0) begin
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall - 1) begin
          @(posedge clk); #2;
          chk("stall_valid_held", int'(out_valid), 1);
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
      if (chain) begin
        in_valid = 1'b1; in_mode = c_mode; tgt_sel = c_tgt; #1;
        chk("chain_load_pulse", int'(dp_load_regs), 1);
        chk("chain_handshake", int'(out_valid && out_ready), 1);
      end
      @(posedge clk); #1; in_valid = 1'b0;
    end
  endtask

  task automatic do_op(input bit mode, input int tgt, input int abort_k, input int stall,
                       input bit chain, input bit c_mode, input int c_tgt,
                       output int lat, output int nops);
    int w;
    w = 0;
    in_valid = 1'b1; in_mode = mode; tgt_sel = tgt; #1;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    wait_result(abort_k, stall, chain, c_mode, c_tgt, lat, nops);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, nops;
    int ps;
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; abort = 1'b0;
    out_ready = 1'b1; tgt_sel = 31;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_err", int'(err), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Nominal rotation: 31 micro-ops, result 33 cycles after accept.
    do_op(1'b0, 31, 0, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("op1_latency", lat, 33);
    chk("op1_microops", nops, 31);
    chk("op1_err", int'(err), 0);
`ifdef CORDIC_CTRL_PERF_EN
    chk("perf_ops_after_op1", int'(perf_ops), 1);
    ps = int'(perf_stall);
`else
    ps = 0;
`endif

    // Result held for 10 cycles with out_ready low.
    do_op(1'b1, 31, 0, 10, 1'b0, 1'b0, 31, lat, nops);
    chk("stall_latency", lat, 33);
`ifdef CORDIC_CTRL_PERF_EN
    chk("perf_stall_10", int'(perf_stall) - ps, 10);
`endif

    // Back-to-back: next accept in the same cycle as the result handshake.
    do_op(1'b0, 31, 0, 0, 1'b1, 1'b1, 31, lat, nops);
    chk("chain_first_latency", lat, 33);
    wait_result(0, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("chain_second_latency", lat, 33);
    chk("chain_second_microops", nops, 31);

    // Abort at T+5: four micro-ops issued before the cancel.
    do_op(1'b1, 31, 5, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("abort_microops", nops, 4);

    // Target never reached: watchdog ends the op and sets err.
    do_op(1'b0, 99, 0, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("watchdog_latency", lat, 33);
    chk("watchdog_microops", nops, 31);
    chk("watchdog_err", int'(err), 1);

    // err is sticky across a clean op; premature target ends early.
    do_op(1'b0, 31, 0, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("err_sticky", int'(err), 1);
    do_op(1'b1, 10, 0, 0, 1'b0, 1'b0, 31, lat, nops);
    chk("early_latency", lat, 12);
    chk("early_microops", nops, 10);

    // Asynchronous reset mid-rotation.
    in_valid = 1'b1; in_mode = 1'b0; tgt_sel = 31;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("areset_dp_iter", int'(dp_iter), 0);
    chk("areset_dp_addsub", int'(dp_add || dp_sub), 0);
    chk("areset_out_valid", int'(out_valid), 0);
    chk("areset_busy", int'(busy), 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("areset_in_ready", int'(in_ready), 1);
    chk("areset_err", int'(err), 0);

    // Random traffic checked cycle by cycle against the model.
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 3) != 0;
      in_mode   = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      abort     = ($urandom % 40) == 0;
      tgt_sel   = (($urandom % 8) == 0) ? int'($urandom_range(0, 40)) : 31;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_cordic_ctrl
